sr_piso_eight: RTL

Parallel-in/serial-out serializer that sits directly downstream of the 8-bit PIPO shift register. It captures the register's parallel output word on a load handshake and shifts it out one bit per clock, with valid, busy and completion signalling. Back-to-back words stream with no idle gap, so the PIPO stage can hold its output and strobe `load` whenever `ready` is high.

---
 rtl/sr_piso_eight.sv | 74 +++++++
 1 files changed

// File: rtl/sr_piso_eight.sv
// Parallel-in/serial-out serializer fed by the 8-bit PIPO stage.
// Accepts a word on load&&ready and shifts it out one bit per clock, reloading gaplessly on the last bit.
module sr_piso_eight #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         inp,
    input  logic                     load,
    output logic                     ready,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH):0]   count
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;

    // ready looks only at state and count, so load never loops back into it
    assign ready      = (state == IDLE) || (count == CW'(1));
    assign busy       = (state == SHIFT);
    assign sout_valid = busy;
    assign sout       = busy ? ((MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0]) : 1'b0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sr    <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        sr    <= inp;
                        count <= CW'(WIDTH);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    done <= (count == CW'(1));
                    if (count == CW'(1) && load) begin
                        sr    <= inp;
                        count <= CW'(WIDTH);
                    end else begin
                        if (MSB_FIRST != 0)
                            sr <= {sr[WIDTH-2:0], 1'b0};
                        else
                            sr <= {1'b0, sr[WIDTH-1:1]};
                        count <= count - CW'(1);
                        if (count == CW'(1))
                            state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
